// File: rtl/sar_multi_ctrl.sv
// Multi-channel successive-approximation ADC controller: scans enabled mux
// channels round-robin, runs one S&H acquisition plus WIDTH bit trials per channel.
module sar_multi_ctrl #(
    parameter int WIDTH      = 8,
    parameter int NCH        = 4,
    parameter int SETTLE     = 10000,
    parameter int SAMPLE_CYC = 16,
    localparam int CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [NCH-1:0]   chan_en,
    input  logic             cmp,
    output logic             sample,
    output logic [CW-1:0]    mux_sel,
    output logic [WIDTH-1:0] dac,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] result,
    output logic [CW-1:0]    result_ch
);

    localparam int MAXC = (SETTLE > SAMPLE_CYC) ? SETTLE : SAMPLE_CYC;
    localparam int CNTW = $clog2(MAXC + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        CONV   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [CNTW-1:0]   cnt_r, cnt_s;
    logic [WIDTH-1:0]  mask_r, mask_s;
    logic [WIDTH-1:0]  code_r, code_s;
    logic [CW-1:0]     mux_s;
    logic [CW-1:0]     last_ch_r;
    logic              have_last_r;
    logic [CW-1:0]     sel_s;

    // First enabled channel: from 0 inclusive, or strictly after last with wrap.
    function automatic logic [CW-1:0] next_chan(input logic [NCH-1:0] en,
                                                input logic [CW-1:0]  last,
                                                input logic           incl);
        logic [CW-1:0]  pick;
        logic [NCH-1:0] sh;
        logic           found;
        int             idx;
        pick  = {CW{1'b0}};
        found = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            idx = incl ? k : ((int'(last) + 1 + k) % NCH);
            sh  = en >> idx;
            if (!found && sh[0]) begin
                pick  = CW'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    // Channel pick: in DONE the channel just converted is the reference point.
    always_comb begin
        if (state_r == DONE) begin
            sel_s = next_chan(chan_en, mux_sel, 1'b0);
        end else begin
            sel_s = next_chan(chan_en, last_ch_r, !have_last_r);
        end
    end

    // Next-state logic and datapath updates for the conversion sequence.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        mask_s  = mask_r;
        code_s  = code_r;
        mux_s   = mux_sel;
        case (state_r)
            IDLE: begin
                if (go && (chan_en != {NCH{1'b0}})) begin
                    state_s = SAMPLE;
                    cnt_s   = {CNTW{1'b0}};
                    mux_s   = sel_s;
                end else begin
                    state_s = IDLE;
                end
            end
            SAMPLE: begin
                if (!go) begin
                    state_s = IDLE;
                    cnt_s   = {CNTW{1'b0}};
                end else if (cnt_r == CNTW'(SAMPLE_CYC - 1)) begin
                    state_s = CONV;
                    cnt_s   = {CNTW{1'b0}};
                    mask_s  = {1'b1, {(WIDTH-1){1'b0}}};
                    code_s  = {WIDTH{1'b0}};
                end else begin
                    cnt_s = cnt_r + CNTW'(1'b1);
                end
            end
            CONV: begin
                if (!go) begin
                    state_s = IDLE;
                    cnt_s   = {CNTW{1'b0}};
                    mask_s  = {WIDTH{1'b0}};
                    code_s  = {WIDTH{1'b0}};
                end else if (cnt_r == CNTW'(SETTLE - 1)) begin
                    // cmp only matters on the final settle cycle of a trial
                    code_s = cmp ? (code_r | mask_r) : code_r;
                    mask_s = mask_r >> 1;
                    cnt_s  = {CNTW{1'b0}};
                    if (mask_r[0]) begin
                        state_s = DONE;
                    end else begin
                        state_s = CONV;
                    end
                end else begin
                    cnt_s = cnt_r + CNTW'(1'b1);
                end
            end
            DONE: begin
                cnt_s = {CNTW{1'b0}};
                if (go && (chan_en != {NCH{1'b0}})) begin
                    state_s = SAMPLE;
                    mux_s   = sel_s;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CNTW{1'b0}};
                mask_s  = {WIDTH{1'b0}};
                code_s  = {WIDTH{1'b0}};
            end
        endcase
    end

    // State, datapath and registered outputs aligned with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= {CNTW{1'b0}};
            mask_r      <= {WIDTH{1'b0}};
            code_r      <= {WIDTH{1'b0}};
            mux_sel     <= {CW{1'b0}};
            last_ch_r   <= {CW{1'b0}};
            have_last_r <= 1'b0;
            sample      <= 1'b0;
            busy        <= 1'b0;
            valid       <= 1'b0;
            dac         <= {WIDTH{1'b0}};
            result      <= {WIDTH{1'b0}};
            result_ch   <= {CW{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            mask_r  <= mask_s;
            code_r  <= code_s;
            mux_sel <= mux_s;
            sample  <= (state_s == SAMPLE);
            busy    <= (state_s != IDLE);
            valid   <= (state_s == DONE);
            dac     <= (state_s == CONV) ? (code_s | mask_s) : {WIDTH{1'b0}};
            if ((state_r == CONV) && (state_s == DONE)) begin
                result    <= code_s;
                result_ch <= mux_sel;
            end else begin
                result    <= result;
                result_ch <= result_ch;
            end
            if (state_r == DONE) begin
                last_ch_r   <= mux_sel;
                have_last_r <= 1'b1;
            end else begin
                last_ch_r   <= last_ch_r;
                have_last_r <= have_last_r;
            end
        end
    end

endmodule

// File: tb/tb_sar_multi_ctrl.sv
// Bench for sar_multi_ctrl: ideal comparator on per-channel input voltages,
// directed scenarios followed by randomized channel masks and input codes.
module tb_sar_multi_ctrl;

    localparam int WIDTH = 8;
    localparam int NCH   = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             go;
    logic [NCH-1:0]   chan_en;
    logic             cmp;
    logic             sample;
    logic [1:0]       mux_sel;
    logic [WIDTH-1:0] dac;
    logic             busy;
    logic             valid;
    logic [WIDTH-1:0] result;
    logic [1:0]       result_ch;

    logic [7:0] vin [NCH];
    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    assign cmp = (vin[mux_sel] >= dac);

    sar_multi_ctrl #(.WIDTH(8), .NCH(4), .SETTLE(4), .SAMPLE_CYC(2)) dut (
        .clk(clk), .reset(reset), .go(go), .chan_en(chan_en), .cmp(cmp),
        .sample(sample), .mux_sel(mux_sel), .dac(dac), .busy(busy),
        .valid(valid), .result(result), .result_ch(result_ch)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin expectation: first enabled channel after last (or from 0).
    function automatic int next_ch(input logic [3:0] en, input int last, input bit have);
        for (int k = 0; k < NCH; k++) begin
            int c;
            c = have ? (last + 1 + k) % NCH : k;
            if (en[c]) return c;
        end
        return 0;
    endfunction

    // Advance until valid, bounded; an expired bound is itself a failure.
    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!valid && n < 200);
        check({tag, "_timeout"}, {31'd0, valid}, 32'd1);
    endtask

    initial begin
        int cyc;
        int last;
        bit have;
        int exp_ch;
        int n;
        logic [7:0] dac_log [64];
        logic [7:0] code;
        logic [7:0] trial;
        logic [7:0] prev_res;
        logic [3:0] en;

        for (int i = 0; i < NCH; i++) vin[i] = 8'h00;
        reset = 1'b1; go = 1'b1; chan_en = 4'b0001; have = 1'b0; last = 0;
        vin[0] = 8'hA5;
        tick(); tick(); tick();
        check("rst_sample", {31'd0, sample}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_dac", {24'd0, dac}, 32'd0);
        check("rst_result", {24'd0, result}, 32'd0);
        check("rst_mux", {30'd0, mux_sel}, 32'd0);
        check("rst_result_ch", {30'd0, result_ch}, 32'd0);

        reset = 1'b0;
        tick();
        check("rel_busy", {31'd0, busy}, 32'd1);
        check("rel_sample", {31'd0, sample}, 32'd1);

        // Single channel, fixed code: latency and DAC trial sequence
        cyc = 0;
        while (!valid && cyc < 60) begin
            dac_log[cyc] = dac;
            tick();
            cyc++;
        end
        check("latency", cyc, 32'd34);
        check("a5_result", {24'd0, result}, 32'hA5);
        check("a5_ch", {30'd0, result_ch}, 32'd0);
        check("a5_samp_dac0", {24'd0, dac_log[0]}, 32'd0);
        check("a5_samp_dac1", {24'd0, dac_log[1]}, 32'd0);
        code = 8'h00;
        for (int b = 7; b >= 0; b--) begin
            trial = code | (8'h01 << b);
            for (int s = 0; s < 4; s++)
                check($sformatf("a5_dac_b%0d_s%0d", b, s), {24'd0, dac_log[2 + (7 - b) * 4 + s]}, {24'd0, trial});
            if (vin[0] >= trial) code = trial;
        end
        last = 0; have = 1'b1;

        // Two channels at rails, then a mask change mid-conversion
        vin[1] = 8'h00; vin[3] = 8'hFF; vin[2] = 8'h5C;
        chan_en = 4'b1010;
        for (int r = 0; r < 4; r++) begin
            exp_ch = next_ch(chan_en, last, have);
            wait_valid("rr");
            check($sformatf("rr%0d_ch", r), {30'd0, result_ch}, exp_ch);
            check($sformatf("rr%0d_res", r), {24'd0, result}, {24'd0, vin[exp_ch]});
            last = exp_ch;
        end
        n = 0;
        while (!(mux_sel == 2'd3 && dac != 8'd0) && n < 200) begin
            tick();
            n++;
        end
        check("ch3_conv_seen", {30'd0, mux_sel}, 32'd3);
        chan_en = 4'b0100;
        wait_valid("midchg");
        check("midchg_ch", {30'd0, result_ch}, 32'd3);
        check("midchg_res", {24'd0, result}, 32'hFF);
        last = 3;
        tick();
        check("midchg_next_ch", {30'd0, mux_sel}, next_ch(chan_en, last, have));
        check("midchg_next_sample", {31'd0, sample}, 32'd1);

        // Abort in the 10th CONV cycle
        prev_res = result;
        n = 0;
        while (dac == 8'd0 && n < 20) begin
            tick();
            n++;
        end
        for (int i = 0; i < 9; i++) tick();
        go = 1'b0;
        tick();
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_dac", {24'd0, dac}, 32'd0);
        check("abort_valid", {31'd0, valid}, 32'd0);
        check("abort_result", {24'd0, result}, {24'd0, prev_res});
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (valid) n++;
        end
        check("abort_no_valid", n, 32'd0);

        // Empty mask keeps the block idle
        go = 1'b1; chan_en = 4'b0000;
        tick(); tick(); tick();
        check("empty_busy", {31'd0, busy}, 32'd0);
        check("empty_sample", {31'd0, sample}, 32'd0);
        chan_en = 4'b0001;
        vin[0] = 8'h3E;
        tick();
        check("empty_go_sample", {31'd0, sample}, 32'd1);
        check("empty_go_mux", {30'd0, mux_sel}, 32'd0);
        wait_valid("ch0");
        check("ch0_res", {24'd0, result}, 32'h3E);
        last = 0;

        // Reset during SAMPLE clears the last-channel pointer
        tick();
        check("pre_rst_sample", {31'd0, sample}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_valid", {31'd0, valid}, 32'd0);
        check("mid_rst_result", {24'd0, result}, 32'd0);
        check("mid_rst_result_ch", {30'd0, result_ch}, 32'd0);
        check("mid_rst_mux", {30'd0, mux_sel}, 32'd0);
        check("mid_rst_sample", {31'd0, sample}, 32'd0);
        have = 1'b0;
        chan_en = 4'b1111;
        tick();
        check("post_rst_mux", {30'd0, mux_sel}, next_ch(chan_en, last, have));
        wait_valid("post_rst");
        check("post_rst_res", {24'd0, result}, 32'h3E);
        last = 0; have = 1'b1;

        // Randomized masks and input codes, changed in each DONE cycle
        for (int r = 0; r < 12; r++) begin
            en = 4'($urandom_range(1, 15));
            for (int i = 0; i < NCH; i++) vin[i] = 8'($urandom);
            chan_en = en;
            exp_ch = next_ch(en, last, have);
            wait_valid("rnd");
            check($sformatf("rnd%0d_ch", r), {30'd0, result_ch}, exp_ch);
            check($sformatf("rnd%0d_res", r), {24'd0, result}, {24'd0, vin[exp_ch]});
            last = exp_ch;
        end

        go = 1'b0;
        tick();
        check("final_idle", {31'd0, busy}, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
